// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/function
// constants, ALU and PC-source selects, and the decoded instruction class.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  typedef struct packed {
    logic rtype;
    logic imm;
    logic lw;
    logic sw;
    logic br;
    logic j;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode: combinational Op/Func decode into instruction class plus the
// ALU select, sign-extend and rt-destination controls.
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic [1:0] aluc,
  output logic       se,
  output logic       regrt
);

  always_comb begin
    cls  = '0;
    aluc = ALUC_ADD;
    se   = 1'b0;
    case (op)
      OP_RTYPE: begin
        cls.rtype = 1'b1;
        case (func)
          FN_ADD:  aluc = ALUC_ADD;
          FN_SUB:  aluc = ALUC_SUB;
          FN_AND:  aluc = ALUC_AND;
          FN_OR:   aluc = ALUC_OR;
          default: begin
            cls.rtype   = 1'b0;
            cls.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin cls.imm = 1'b1; se = 1'b1; end
      OP_ANDI: begin cls.imm = 1'b1; aluc = ALUC_AND; end
      OP_ORI:  begin cls.imm = 1'b1; aluc = ALUC_OR; end
      OP_LW:   begin cls.lw = 1'b1; se = 1'b1; end
      OP_SW:   begin cls.sw = 1'b1; se = 1'b1; end
      OP_BEQ, OP_BNE: begin
        cls.br = 1'b1;
        se     = 1'b1;
        aluc   = ALUC_SUB;
      end
      OP_J:    cls.j = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

  // Only R-type writes rd; everything else that writes back targets rt.
  assign regrt = ~cls.rtype;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EX/MEM/WB) with memory handshake.
// Optional retired-instruction counter RetCnt when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Z,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IrWrite,
  output logic       PcWrite,
  output logic       Regrt,
  output logic       Se,
  output logic       Wreg,
  output logic       Aluqb,
  output logic       Wmem,
  output logic       Reg2reg,
  output logic [1:0] Aluc,
  output logic [1:0] Pcsrc,
  output logic       Illegal,
  output logic [2:0] State
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] RetCnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_t     state_q, state_d;
  iclass_t    cls;
  logic [1:0] dec_aluc;
  logic       dec_se, dec_regrt;
  logic       taken;

  logic       memreq, irwrite, pcwrite, regrt, se, wreg, aluqb, wmem, reg2reg, illegal;
  logic [1:0] aluc, pcsrc;

  mc_decode u_decode (
    .op    (Op),
    .func  (Func),
    .cls   (cls),
    .aluc  (dec_aluc),
    .se    (dec_se),
    .regrt (dec_regrt)
  );

  assign taken = (Op == OP_BEQ) ? Z : ~Z;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IF;
    memreq  = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    regrt   = 1'b0;
    se      = 1'b0;
    wreg    = 1'b0;
    aluqb   = 1'b0;
    wmem    = 1'b0;
    reg2reg = 1'b0;
    illegal = 1'b0;
    aluc    = ALUC_ADD;
    pcsrc   = PCSRC_PC4;
    case (state_q)
      ST_IF: begin
        memreq = 1'b1;
        if (MemReady) begin
          irwrite = 1'b1;
          state_d = ST_ID;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_ID: begin
        if (cls.j) begin
          pcwrite = 1'b1;
          pcsrc   = PCSRC_J;
        end else if (cls.illegal) begin
          illegal = 1'b1;
          pcwrite = 1'b1;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        aluc  = dec_aluc;
        se    = dec_se;
        aluqb = cls.rtype | cls.br;
        if (cls.br) begin
          pcwrite = 1'b1;
          pcsrc   = taken ? PCSRC_BR : PCSRC_PC4;
        end else if (cls.lw | cls.sw) begin
          state_d = ST_MEM;
        end else if (cls.rtype | cls.imm) begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // ALU controls stay put so the address computed in EX remains stable.
        aluc   = dec_aluc;
        se     = dec_se;
        aluqb  = cls.rtype | cls.br;
        memreq = 1'b1;
        wmem   = cls.sw;
        if (!MemReady) begin
          state_d = ST_MEM;
        end else if (cls.sw) begin
          pcwrite = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        aluc    = dec_aluc;
        se      = dec_se;
        aluqb   = cls.rtype | cls.br;
        wreg    = 1'b1;
        pcwrite = 1'b1;
        regrt   = dec_regrt;
        reg2reg = ~cls.lw;
      end
      default: state_d = ST_IF;
    endcase
  end

  // Everything, MemReq included, is forced quiet while reset is held.
  assign MemReq  = Reset & memreq;
  assign IrWrite = Reset & irwrite;
  assign PcWrite = Reset & pcwrite;
  assign Regrt   = Reset & regrt;
  assign Se      = Reset & se;
  assign Wreg    = Reset & wreg;
  assign Aluqb   = Reset & aluqb;
  assign Wmem    = Reset & wmem;
  assign Reg2reg = Reset & reg2reg;
  assign Illegal = Reset & illegal;
  assign Aluc    = Reset ? aluc  : 2'b00;
  assign Pcsrc   = Reset ? pcsrc : 2'b00;
  assign State   = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] ret_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)       ret_cnt <= '0;
    else if (PcWrite) ret_cnt <= ret_cnt + CNT_W'(1);
  end

  assign RetCnt = ret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction table plus wait-state,
// reset-abort and (with MULTICYCLE_PERF_CNT_EN) counter-wrap sequences.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Op, Func;
  logic       Z, MemReady;
  logic       MemReq, IrWrite, PcWrite, Regrt, Se, Wreg, Aluqb, Wmem, Reg2reg, Illegal;
  logic [1:0] Aluc, Pcsrc;
  logic [2:0] State;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [CNT_W-1:0] RetCnt;
`endif

  int errors = 0;
  int checks = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Func(Func), .Z(Z), .MemReady(MemReady),
    .MemReq(MemReq), .IrWrite(IrWrite), .PcWrite(PcWrite), .Regrt(Regrt), .Se(Se),
    .Wreg(Wreg), .Aluqb(Aluqb), .Wmem(Wmem), .Reg2reg(Reg2reg), .Aluc(Aluc),
    .Pcsrc(Pcsrc), .Illegal(Illegal), .State(State)
`ifdef MULTICYCLE_PERF_CNT_EN
    , .RetCnt(RetCnt)
`endif
  );

  always #5 Clk = ~Clk;

  logic [16:0] outv;
  assign outv = {MemReq, IrWrite, PcWrite, Regrt, Se, Wreg, Aluqb, Wmem, Reg2reg,
                 Aluc, Pcsrc, Illegal, State};

  typedef struct {
    logic [5:0]  op, func;
    logic        z;
    logic [14:0] seq;
    int          len;
    logic [1:0]  pcsrc, aluc;
    logic        aluqb, se;
    int          wreg, wmem, ill, mreq;
    logic        regrt, r2r;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic [5:0] op, logic [5:0] func, logic z, logic [14:0] seq,
                              int len, logic [1:0] pcsrc, logic [1:0] aluc, logic aluqb,
                              logic se, int wreg, int wmem, int ill, int mreq,
                              logic regrt, logic r2r);
    vec_t v;
    v.op = op; v.func = func; v.z = z; v.seq = seq; v.len = len; v.pcsrc = pcsrc;
    v.aluc = aluc; v.aluqb = aluqb; v.se = se; v.wreg = wreg; v.wmem = wmem;
    v.ill = ill; v.mreq = mreq; v.regrt = regrt; v.r2r = r2r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction from IF with MemReady=1 until its PcWrite cycle.
  task automatic run_vec(input int idx);
    vec_t v;
    logic [14:0] seq = '0;
    int n = 0, pcw = 0, wreg = 0, wmem = 0, ill = 0, mreq = 0, irw = 0;
    logic [1:0] pcsrc = 2'b00, aluc = 2'b00;
    logic aluqb = 1'b0, se = 1'b0, regrt = 1'b0, r2r = 1'b0;
    bit done = 0;
    string nm;
    v = tbl[idx];
    nm = $sformatf("vec%0d", idx);
    for (int c = 0; c < 10 && !done; c++) begin
      #1;
      Op = v.op; Func = v.func; Z = v.z; MemReady = 1'b1;
      @(negedge Clk);
      seq = (seq << 3) | 15'(State);
      n++;
      if (State == 3'd2) begin aluc = Aluc; aluqb = Aluqb; se = Se; end
      if (PcWrite) begin pcw++; pcsrc = Pcsrc; done = 1; end
      if (Wreg) begin wreg++; regrt = Regrt; r2r = Reg2reg; end
      wmem += int'(Wmem);
      ill  += int'(Illegal);
      mreq += int'(MemReq);
      irw  += int'(IrWrite);
      @(posedge Clk);
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s timeout: no PcWrite within 10 cycles", nm);
    end
    #1;
    chk({nm, " back_to_if"}, 32'(State), 32'd0);
    chk({nm, " states"},  32'(seq),   32'(v.seq));
    chk({nm, " latency"}, 32'(n),     32'(v.len));
    chk({nm, " pcwrite"}, 32'(pcw),   32'd1);
    chk({nm, " pcsrc"},   32'(pcsrc), 32'(v.pcsrc));
    chk({nm, " aluc"},    32'(aluc),  32'(v.aluc));
    chk({nm, " aluqb"},   32'(aluqb), 32'(v.aluqb));
    chk({nm, " se"},      32'(se),    32'(v.se));
    chk({nm, " wreg"},    32'(wreg),  32'(v.wreg));
    chk({nm, " wmem"},    32'(wmem),  32'(v.wmem));
    chk({nm, " illegal"}, 32'(ill),   32'(v.ill));
    chk({nm, " memreq"},  32'(mreq),  32'(v.mreq));
    chk({nm, " irwrite"}, 32'(irw),   32'd1);
    chk({nm, " regrt"},   32'(regrt), 32'(v.regrt));
    chk({nm, " reg2reg"}, 32'(r2r),   32'(v.r2r));
  endtask

  int lw_st [9] = '{0, 0, 1, 2, 3, 3, 3, 3, 4};
  logic lw_mr [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    //            op     func   z    seq       len pcs   aluc  qb   se   wr wm il mr rt   r2r
    tbl[0]  = mk(6'h00, 6'h20, 0, 15'o124,  4, 2'd0, 2'd0, 1, 0, 1, 0, 0, 1, 0, 1);
    tbl[1]  = mk(6'h00, 6'h22, 0, 15'o124,  4, 2'd0, 2'd1, 1, 0, 1, 0, 0, 1, 0, 1);
    tbl[2]  = mk(6'h00, 6'h24, 0, 15'o124,  4, 2'd0, 2'd2, 1, 0, 1, 0, 0, 1, 0, 1);
    tbl[3]  = mk(6'h00, 6'h25, 0, 15'o124,  4, 2'd0, 2'd3, 1, 0, 1, 0, 0, 1, 0, 1);
    tbl[4]  = mk(6'h08, 6'h3F, 0, 15'o124,  4, 2'd0, 2'd0, 0, 1, 1, 0, 0, 1, 1, 1);
    tbl[5]  = mk(6'h0C, 6'h3F, 0, 15'o124,  4, 2'd0, 2'd2, 0, 0, 1, 0, 0, 1, 1, 1);
    tbl[6]  = mk(6'h0D, 6'h00, 0, 15'o124,  4, 2'd0, 2'd3, 0, 0, 1, 0, 0, 1, 1, 1);
    tbl[7]  = mk(6'h23, 6'h00, 0, 15'o1234, 5, 2'd0, 2'd0, 0, 1, 1, 0, 0, 2, 1, 0);
    tbl[8]  = mk(6'h2B, 6'h00, 0, 15'o123,  4, 2'd0, 2'd0, 0, 1, 0, 1, 0, 2, 0, 0);
    tbl[9]  = mk(6'h04, 6'h00, 1, 15'o12,   3, 2'd2, 2'd1, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(6'h04, 6'h00, 0, 15'o12,   3, 2'd0, 2'd1, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[11] = mk(6'h05, 6'h00, 1, 15'o12,   3, 2'd0, 2'd1, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[12] = mk(6'h05, 6'h00, 0, 15'o12,   3, 2'd2, 2'd1, 1, 1, 0, 0, 0, 1, 0, 0);
    tbl[13] = mk(6'h02, 6'h00, 0, 15'o1,    2, 2'd3, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[14] = mk(6'h3F, 6'h00, 0, 15'o1,    2, 2'd0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[15] = mk(6'h00, 6'h21, 0, 15'o1,    2, 2'd0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[16] = mk(6'h01, 6'h20, 0, 15'o1,    2, 2'd0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0);

    // Reset held with a fetch pending: everything must stay at zero.
    Reset = 1'b0; Op = 6'h23; Func = 6'h00; Z = 1'b0; MemReady = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset outputs", 32'(outv), 32'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("reset retcnt", 32'(RetCnt), 32'd0);
`endif
    MemReady = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);

    for (int i = 0; i < 17; i++) run_vec(i);

    // lw with one IF wait state and three MEM wait states.
    for (int i = 0; i < 9; i++) begin
      #1;
      Op = 6'h23; Func = 6'h00; Z = 1'b0; MemReady = lw_mr[i];
      @(negedge Clk);
      chk($sformatf("lw_wait state c%0d", i), 32'(State), 32'(lw_st[i]));
      if (i < 2 || lw_st[i] == 3) chk($sformatf("lw_wait memreq c%0d", i), 32'(MemReq), 32'd1);
      if (i == 0) chk("lw_wait irwrite stalled", 32'(IrWrite), 32'd0);
      if (i == 7) chk("lw_wait mem pcwrite", 32'(PcWrite), 32'd0);
      if (i == 8) chk("lw_wait wb {wreg,regrt,reg2reg,pcwrite}",
                      32'({Wreg, Regrt, Reg2reg, PcWrite}), 32'b1101);
      @(posedge Clk);
    end
    #1;
    chk("lw_wait back_to_if", 32'(State), 32'd0);

    // sw aborted by reset while stalled in MEM.
    for (int i = 0; i < 3; i++) begin
      #1;
      Op = 6'h2B; MemReady = 1'b1;
      @(posedge Clk);
    end
    #1;
    MemReady = 1'b0;
    @(negedge Clk);
    chk("sw_abort in mem {state,wmem}", 32'({State, Wmem}), 32'({3'd3, 1'b1}));
    #1;
    Reset = 1'b0;
    #1;
    chk("sw_abort immediate outputs", 32'(outv), 32'd0);
    @(posedge Clk);
    #1;
    chk("sw_abort held outputs", 32'(outv), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("sw_abort release {state,memreq,irwrite}", 32'({State, MemReq, IrWrite}),
        32'({3'd0, 1'b1, 1'b0}));
    @(posedge Clk);
    run_vec(0);

`ifdef MULTICYCLE_PERF_CNT_EN
    @(negedge Clk);
    Reset = 1'b0;
    MemReady = 1'b0;
    #1;
    chk("cnt cleared", 32'(RetCnt), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    for (int i = 0; i < 17; i++) run_vec((i % 2 == 0) ? 13 : 14);
    chk("cnt wrapped after 17", 32'(RetCnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
